// File: rtl/lab3_io_pkg.sv
// lab3_io_pkg
//   Shared constants for the Lab 3 input path: board clock rate, default
//   debounce window, and the auto-repeat timing defaults for the centre
//   button. The repeat defaults only take effect when the block is built
//   with LAB3_BTN_AUTOREPEAT_EN defined.
package lab3_io_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int DEBOUNCE_MS = 10;

    // 10 ms at 100 MHz -> 1_000_000 cycles
    localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // 0.5 s before the first repeat, then one repeat every 0.1 s
    localparam int REPEAT_DELAY_DEF  = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_DEF = CLK_HZ / 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lab3_debounce_bit.sv
// lab3_debounce_bit
//   One input lane: SYNC_STAGES-deep synchroniser followed by a stability
//   counter. The output q only follows the synchronised input after it has
//   disagreed with q for DEBOUNCE_CYCLES consecutive cycles; any shorter
//   excursion clears the count and is lost.
// Ports:
//   fpga_clk  in   system clock
//   reset     in   asynchronous, active-high reset
//   d_raw     in   raw (asynchronous) pin level
//   q         out  synchronised, debounced level
module lab3_debounce_bit
    import lab3_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic fpga_clk,
    input  logic reset,
    input  logic d_raw,
    output logic q
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   d_sync;

    assign d_sync = sync[SYNC_STAGES-1];

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            q    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_raw};
            if (d_sync == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Disagreed for the full window: accept and restart.
                q   <= d_sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/lab3_input_conditioner.sv
// lab3_input_conditioner
//   Conditions the raw slide switches and centre button for the Lab 3
//   switch/step controller: every input is synchronised and debounced on
//   its own lane, and a registered one-cycle press pulse is produced for
//   the button.
//   Build option: define LAB3_BTN_AUTOREPEAT_EN to add auto-repeat pulses
//   while the button is held (first repeat REPEAT_DELAY cycles after the
//   press pulse, then every REPEAT_PERIOD cycles). Without it the REPEAT_*
//   parameters have no effect.
// Ports:
//   fpga_clk      in   system clock
//   reset         in   asynchronous, active-high reset
//   switches_raw  in   NUM_SW raw switch pins
//   btnC_raw      in   raw centre button pin
//   switches      out  NUM_SW debounced switch levels
//   btnC          out  debounced button level
//   btnC_pulse    out  one-cycle pulse per accepted press (and per repeat)
module lab3_input_conditioner
    import lab3_io_pkg::*;
#(
    parameter int NUM_SW          = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic              fpga_clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] switches_raw,
    input  logic              btnC_raw,
    output logic [NUM_SW-1:0] switches,
    output logic              btnC,
    output logic              btnC_pulse
);

    // Button rides on the top lane so all inputs share one generate loop.
    logic [NUM_SW:0] raw_all;
    logic [NUM_SW:0] deb_all;

    assign raw_all = {btnC_raw, switches_raw};

    genvar i;
    generate
        for (i = 0; i <= NUM_SW; i++) begin : g_lane
            lab3_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .fpga_clk (fpga_clk),
                .reset    (reset),
                .d_raw    (raw_all[i]),
                .q        (deb_all[i])
            );
        end
    endgenerate

    assign switches = deb_all[NUM_SW-1:0];
    assign btnC     = deb_all[NUM_SW];

    logic btnC_d;
    logic btnC_rise;

    assign btnC_rise = btnC & ~btnC_d;

`ifdef LAB3_BTN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    // rep_cnt counts cycles since the last pulse while the button is held;
    // rep_first_done selects the long initial delay vs the short period.
    logic [REP_W-1:0] rep_cnt;
    logic             rep_first_done;
    logic             rep_fire;

    assign rep_fire = btnC & btnC_d &
                      (rep_first_done ? (rep_cnt == PERIOD_LAST)
                                      : (rep_cnt == DELAY_LAST));

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            btnC_d         <= 1'b0;
            btnC_pulse     <= 1'b0;
            rep_cnt        <= '0;
            rep_first_done <= 1'b0;
        end else begin
            btnC_d     <= btnC;
            btnC_pulse <= btnC_rise | rep_fire;
            if (!btnC || btnC_rise) begin
                // Released, or this cycle issues the initial press pulse.
                rep_cnt        <= '0;
                rep_first_done <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt        <= '0;
                rep_first_done <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end
`else
    // Repeat timing is not built in this configuration.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            btnC_d     <= 1'b0;
            btnC_pulse <= 1'b0;
        end else begin
            btnC_d     <= btnC;
            btnC_pulse <= btnC_rise;
        end
    end
`endif

endmodule

// File: tb/tb_lab3_input_conditioner.sv
// tb_lab3_input_conditioner
//   Self-checking bench: directed sequences for reset, press, bounce and
//   release timing, a table of switch-bus vectors, and randomised stimulus
//   compared every cycle against a window-based reference model.
module tb_lab3_input_conditioner;

    localparam int NSW = 16;
    localparam int SS  = 2;
    localparam int DC  = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;

`ifdef LAB3_BTN_AUTOREPEAT_EN
    localparam int EXP_PRESS_PULSES = 7;
`else
    localparam int EXP_PRESS_PULSES = 1;
`endif

    logic            fpga_clk = 1'b0;
    logic            reset = 1'b0;
    logic [NSW-1:0]  switches_raw = '0;
    logic            btnC_raw = 1'b0;
    logic [NSW-1:0]  switches;
    logic            btnC;
    logic            btnC_pulse;

    always #5 fpga_clk = ~fpga_clk;

    lab3_input_conditioner #(
        .NUM_SW          (NSW),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .fpga_clk     (fpga_clk),
        .reset        (reset),
        .switches_raw (switches_raw),
        .btnC_raw     (btnC_raw),
        .switches     (switches),
        .btnC         (btnC),
        .btnC_pulse   (btnC_pulse)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // raw_hist: samples still travelling through the synchroniser.
    // win: the last DC values the debouncer has seen; a bit flips when all
    // of them disagree with its current output.
    // m_k: edges since the button's accepted rise (-1 when not held).
    logic [NSW:0] raw_hist[$];
    logic [NSW:0] win[$];
    logic [NSW:0] m_q;
    logic         m_pulse;
    int           m_k;
    bit           chk_en = 1'b0;

    task automatic model_clear();
        raw_hist = {};
        for (int s = 0; s < SS; s++) raw_hist.push_back('0);
        win     = {};
        m_q     = '0;
        m_pulse = 1'b0;
        m_k     = -1;
    endtask

    task automatic model_step();
        logic [NSW:0] seen;
        logic [NSW:0] nq;
        logic         old_b;
        int           k1;
        if (reset) begin
            model_clear();
            return;
        end
        seen = raw_hist.pop_front();
        raw_hist.push_back({btnC_raw, switches_raw});
        win.push_back(seen);
        if (win.size() > DC) void'(win.pop_front());
        old_b = m_q[NSW];
        nq = m_q;
        if (win.size() == DC) begin
            for (int b = 0; b <= NSW; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                foreach (win[j]) if (win[j][b] == m_q[b]) all_diff = 1'b0;
                if (all_diff) nq[b] = ~m_q[b];
            end
        end
        m_pulse = 1'b0;
        k1 = 0;
        if (old_b && m_k >= 0) begin
            m_k++;
            if (m_k == 1) m_pulse = 1'b1;
`ifdef LAB3_BTN_AUTOREPEAT_EN
            k1 = m_k - 1;
            if (k1 == RD || (k1 > RD && ((k1 - RD) % RP) == 0)) m_pulse = 1'b1;
`endif
        end
        m_q = nq;
        if (!nq[NSW]) m_k = -1;
        else if (!old_b) m_k = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge fpga_clk);
            model_step();
        end
    end

    initial forever begin
        @(posedge reset);
        model_clear();
    end

    initial forever begin
        @(negedge fpga_clk);
        if (chk_en) check("model", {btnC_pulse, btnC, switches}, {m_pulse, m_q});
    end

    // ---------------- directed / table / random ----------------
    typedef struct {
        logic [NSW-1:0] raw;
        int             hold;
        logic [NSW-1:0] exp;
    } sw_vec_t;

    sw_vec_t tbl[12];

    task automatic cyc(input int n);
        repeat (n) @(negedge fpga_clk);
    endtask

    initial begin
        int pc;
        int first;
        int bad;
        int sw_hold;
        int btn_hold;

        tbl[0]  = '{16'h0000, 20, 16'h0000};
        tbl[1]  = '{16'hA5A5,  9, 16'h0000};
        tbl[2]  = '{16'hA5A5,  1, 16'hA5A5};
        tbl[3]  = '{16'hA5AD,  7, 16'hA5A5};
        tbl[4]  = '{16'hA5A5, 12, 16'hA5A5};
        tbl[5]  = '{16'hA5AD,  8, 16'hA5A5};
        tbl[6]  = '{16'hA5A5,  2, 16'hA5AD};
        tbl[7]  = '{16'hA5A5,  9, 16'hA5A5};
        tbl[8]  = '{16'hFFFF, 10, 16'hFFFF};
        tbl[9]  = '{16'h1234,  9, 16'hFFFF};
        tbl[10] = '{16'h1234,  1, 16'h1234};
        tbl[11] = '{16'h0000, 10, 16'h0000};

        // Reset state: outputs clear without any clock edge.
        #2 reset = 1'b1;
        #1 check("reset_state", {btnC_pulse, btnC, switches}, '0);
        cyc(2);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset mid-debounce, button held through release.
        switches_raw = 16'h00FF;
        cyc(20);
        check("pre_reset_sw", switches, 16'h00FF);
        btnC_raw = 1'b1;
        cyc(5);
        #3 reset = 1'b1;
        #1 check("reset_async", {btnC_pulse, btnC, switches}, '0);
        @(negedge fpga_clk);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge fpga_clk);
            if (i == 9)  check("rst_btn_e8", btnC, 1'b0);
            if (i == 10) check("rst_btn_e9", btnC, 1'b1);
            if (i == 10) check("rst_sw_e9", switches, 16'h00FF);
            if (i == 11) check("rst_held_pulse", btnC_pulse, 1'b1);
            if (i == 12) check("rst_held_pulse_end", btnC_pulse, 1'b0);
        end
        btnC_raw = 1'b0;
        switches_raw = '0;
        cyc(30);

        // Clean press, held.
        btnC_raw = 1'b1;
        pc = 0;
        first = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge fpga_clk);
            if (i == 9)  check("press_btn_e8", btnC, 1'b0);
            if (i == 10) check("press_btn_e9", btnC, 1'b1);
            if (i == 10) check("press_pulse_e9", btnC_pulse, 1'b0);
            if (i == 12) check("press_pulse_e11", btnC_pulse, 1'b0);
            if (btnC_pulse) begin
                pc++;
                if (first < 0) first = i;
            end
        end
        check("press_first_pulse", first, 11);
        check("press_pulse_count", pc, EXP_PRESS_PULSES);

        // Release.
        btnC_raw = 1'b0;
        pc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge fpga_clk);
            if (i == 9)  check("rel_btn_e8", btnC, 1'b1);
            if (i == 10) check("rel_btn_e9", btnC, 1'b0);
            if (i >= 10 && btnC_pulse) pc++;
        end
        check("rel_no_pulse", pc, 0);
        cyc(10);

        // Bounce every 3 cycles, then settle high.
        bad = 0;
        for (int seg = 0; seg < 10; seg++) begin
            btnC_raw = (seg % 2 == 0);
            for (int r = 0; r < 3; r++) begin
                @(negedge fpga_clk);
                if (btnC !== 1'b0 || btnC_pulse !== 1'b0) bad++;
            end
        end
        check("bounce_btn_low", bad, 0);
        btnC_raw = 1'b1;
        pc = 0;
        first = -1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge fpga_clk);
            if (i == 9) check("bounce_btn_e8", btnC, 1'b0);
            if (btnC_pulse) begin
                pc++;
                if (first < 0) first = i;
            end
        end
        check("bounce_first_pulse", first, 11);
        check("bounce_pulse_count", pc, 1);
        btnC_raw = 1'b0;
        cyc(20);

        // Switch-bus vector table.
        for (int k = 0; k < 12; k++) begin
            switches_raw = tbl[k].raw;
            cyc(tbl[k].hold);
            check($sformatf("sw_tbl%0d", k), switches, tbl[k].exp);
        end

        // Randomised stimulus against the model, with one reset mid-run.
        sw_hold  = 0;
        btn_hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (sw_hold == 0) begin
                switches_raw = switches_raw ^ NSW'($urandom & $urandom);
                sw_hold = $urandom_range(1, 20);
            end
            if (btn_hold == 0) begin
                btnC_raw = ~btnC_raw;
                btn_hold = $urandom_range(1, 45);
            end
            sw_hold--;
            btn_hold--;
            if (c == 700) begin
                #2 reset = 1'b1;
                #1 check("rand_reset_async", {btnC_pulse, btnC, switches}, '0);
                @(negedge fpga_clk);
                reset = 1'b0;
            end else begin
                @(negedge fpga_clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
